// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HIGH,
    WAIT_START,
    MEASURE,
    CHECK_STOP,
    DONE,
    ERROR
  } ab_state_e;

  localparam int SYNC_SEGMENTS = 9;
  localparam int TOT_SHIFT     = 6;
  localparam int SEG_W         = 19;
  localparam int TOT_W         = 22;
  localparam int LEN_W         = SEG_W + 1;

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchronizer, resets to the idle-high level
module uart_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - measures a 0x55 sync character and derives the UART prescale
module uart_autobaud
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd54,
  parameter int          TOL_SHIFT        = 2,
  parameter int          MAX_SEG          = (1 << 19) - 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        arm,
  output logic [15:0] prescale,
  output logic        locked,
  output logic        lock,
  output logic        error,
  output logic        busy
);

  localparam logic [SEG_W-1:0] MAX_SEG_V  = SEG_W'(MAX_SEG);
  localparam logic [3:0]       LAST_INDEX = 4'(SYNC_SEGMENTS - 1);

  logic rxd_s;
  logic prev_q;
  logic fall_q;
  logic rise_q;
  logic any_edge;

  ab_state_e        state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       idx_q, idx_d;
  logic             stop_q, stop_d;
  logic [15:0]      prescale_q, prescale_d;
  logic             locked_q, locked_d;

  logic [LEN_W-1:0] seg_len;
  logic [LEN_W-1:0] tol;
  logic [LEN_W-1:0] lo_bound;
  logic [LEN_W-1:0] hi_bound;
  logic             in_tol;
  logic             timeout;
  logic [SEG_W-1:0] seg_inc;
  logic [TOT_W-1:0] tot_inc;
  logic [15:0]      p_val;

  uart_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  // Edge pulses are registered so every interval sees the same fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= rxd_s;
      fall_q <= prev_q & ~rxd_s;
      rise_q <= ~prev_q & rxd_s;
    end
  end

  assign any_edge = fall_q | rise_q;

  // seg_q counts cycles since the last edge minus one, so seg_len is the true length.
  assign seg_len  = {1'b0, seg_q} + LEN_W'(1);
  assign tol      = len_q >> TOL_SHIFT;
  assign lo_bound = len_q - tol;
  assign hi_bound = len_q + tol;
  assign in_tol   = (seg_len >= lo_bound) && (seg_len <= hi_bound);
  assign timeout  = (seg_q == MAX_SEG_V);
  assign seg_inc  = seg_q + SEG_W'(1);
  assign tot_inc  = (tot_q == {TOT_W{1'b1}}) ? tot_q : tot_q + TOT_W'(1);
  assign p_val    = 16'(({1'b0, tot_q} + (TOT_W + 1)'(32)) >> TOT_SHIFT);

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    tot_d      = tot_q;
    len_d      = len_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    prescale_d = prescale_q;
    locked_d   = locked_q;

    case (state_q)
      IDLE: begin
        if (arm) state_d = WAIT_HIGH;
      end

      WAIT_HIGH: begin
        if (prev_q) state_d = WAIT_START;
      end

      WAIT_START: begin
        if (fall_q) begin
          seg_d   = '0;
          tot_d   = '0;
          idx_d   = 4'd1;
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        seg_d = seg_inc;
        tot_d = tot_inc;
        if (timeout) begin
          state_d = ERROR;
        end else if (any_edge) begin
          seg_d = '0;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd1) begin
            len_d = seg_len;
          end else if (!in_tol) begin
            state_d = ERROR;
          end else if (idx_q == LAST_INDEX) begin
            // tot_d already holds the first-to-last falling edge span; it is frozen from here.
            stop_d  = 1'b0;
            state_d = CHECK_STOP;
          end
        end
      end

      CHECK_STOP: begin
        seg_d = seg_inc;
        if (timeout) begin
          state_d = ERROR;
        end else if (!stop_q) begin
          if (any_edge) begin
            seg_d = '0;
            if (in_tol) stop_d = 1'b1;
            else        state_d = ERROR;
          end
        end else if (fall_q) begin
          state_d = ERROR;
        end else if (seg_len >= lo_bound) begin
          if (p_val == 16'd0) begin
            state_d = ERROR;
          end else begin
            prescale_d = p_val;
            locked_d   = 1'b1;
            state_d    = DONE;
          end
        end
      end

      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      seg_q      <= '0;
      tot_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      prescale_q <= DEFAULT_PRESCALE;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      tot_q      <= tot_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      prescale_q <= prescale_d;
      locked_q   <= locked_d;
    end
  end

  // Pulses decode from the registered state, so lock and error can never coincide.
  assign lock     = (state_q == DONE);
  assign error    = (state_q == ERROR);
  assign busy     = (state_q != IDLE);
  assign prescale = prescale_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// tb/tb_uart_autobaud.sv - scoreboard bench for uart_autobaud
module tb_uart_autobaud;

  localparam int MAXS = 4095;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic        arm;
  logic [15:0] prescale;
  logic        locked;
  logic        lock;
  logic        error;
  logic        busy;

  typedef struct {
    bit          is_lock;
    logic [15:0] ps;
    bit          lk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests;
  int   fails;

  uart_autobaud #(
    .DEFAULT_PRESCALE (16'd54),
    .TOL_SHIFT        (2),
    .MAX_SEG          (MAXS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .arm      (arm),
    .prescale (prescale),
    .locked   (locked),
    .lock     (lock),
    .error    (error),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (lock === 1'b1 || error === 1'b1) begin
      check("lock_error_exclusive", {31'd0, lock & error}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got lock=%0b error=%0b expected no pulse", lock, error);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_lock", {31'd0, lock}, {31'd0, mon_e.is_lock});
        check("pulse_error", {31'd0, error}, {31'd0, !mon_e.is_lock});
        check("pulse_prescale", {16'd0, prescale}, {16'd0, mon_e.ps});
        check("pulse_locked", {31'd0, locked}, {31'd0, mon_e.lk});
      end
    end
  end

  task automatic hold(input logic level, input int n);
    rxd = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input bit is_lock, input logic [15:0] ps, input bit lk);
    exp_t e;
    e.is_lock = is_lock;
    e.ps      = ps;
    e.lk      = lk;
    exp_q.push_back(e);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    check("busy_after_arm", {31'd0, busy}, 32'd1);
    hold(1'b1, 5);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bt, input int st_bit, input int st_len);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      hold(frame[i], (i == st_bit) ? st_len : bt);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d pending events expected 0", name, exp_q.size());
      exp_q.delete();
    end
    hold(1'b1, 10);
    check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_prescale"}, {16'd0, prescale}, 32'd54);
    check({name, "_locked"}, {31'd0, locked}, 32'd0);
    check({name, "_lock"}, {31'd0, lock}, 32'd0);
    check({name, "_error"}, {31'd0, error}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    rxd   = 1'b1;
    arm   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    hold(1'b1, 5);
    check_reset_outputs("post_reset");

    // 3 clk/bit: total 24 rounds to p=0, so the lock is refused.
    do_arm();
    expect_evt(1'b0, 16'd54, 1'b0);
    send_frame(8'h55, 3, -1, 0);
    wait_drain("p_zero", 2000);
    check("p_zero_prescale", {16'd0, prescale}, 32'd54);

    do_arm();
    expect_evt(1'b1, 16'd54, 1'b1);
    send_frame(8'h55, 432, -1, 0);
    wait_drain("clean_432", 2000);
    check("clean_432_locked", {31'd0, locked}, 32'd1);
    check("clean_432_prescale", {16'd0, prescale}, 32'd54);

    // d1 (frame bit 2) stretched to 120: total 820 -> (820+32)>>6 = 13.
    do_arm();
    expect_evt(1'b1, 16'd13, 1'b1);
    send_frame(8'h55, 100, 2, 120);
    wait_drain("stretch_120", 2000);

    do_arm();
    expect_evt(1'b0, 16'd13, 1'b1);
    send_frame(8'h55, 100, 2, 130);
    wait_drain("stretch_130", 2000);
    check("stretch_130_prescale", {16'd0, prescale}, 32'd13);

    do_arm();
    expect_evt(1'b0, 16'd13, 1'b1);
    send_frame(8'h41, 432, -1, 0);
    wait_drain("char_41", 2000);

    do_arm();
    expect_evt(1'b1, 16'd100, 1'b1);
    send_frame(8'h55, 800, -1, 0);
    wait_drain("clean_800", 2000);
    check("clean_800_prescale", {16'd0, prescale}, 32'd100);

    do_arm();
    expect_evt(1'b0, 16'd100, 1'b1);
    hold(1'b0, MAXS + 10);
    hold(1'b1, 20);
    wait_drain("timeout", 2000);

    do_arm();
    hold(1'b0, 432);
    hold(1'b1, 200);
    rst_n = 1'b0;
    hold(1'b1, 3);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    hold(1'b1, 5);
    check_reset_outputs("mid_reset_release");

    do_arm();
    expect_evt(1'b1, 16'd54, 1'b1);
    send_frame(8'h55, 432, -1, 0);
    wait_drain("after_reset_432", 2000);
    check("after_reset_prescale", {16'd0, prescale}, 32'd54);

    hold(1'b1, 50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Measures the baud rate of an incoming UART line from a single 0x55 sync character and produces the `prescale` value used by the UART transmitter and receiver (clocks per bit = prescale × 8). Sits upstream of the UART: it shares `rxd` with the receiver and drives its `prescale` input. Until the first successful lock it presents a fixed default. After that it holds the last locked value.

## Interface
- `DEFAULT_PRESCALE`, 16'd54: `prescale` output after reset and until the first lock.
- `TOL_SHIFT`, 2: segment tolerance is L >> TOL_SHIFT, where L is the start-bit length (±25% by default).
- `MAX_SEG`, 2^19−1: a segment exceeding this many clocks is a timeout.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rxd`  in  1  asynchronous UART line (idle high).
- `arm`  in  1  single-cycle request to measure the next character. Ignored while `busy`.
- `prescale`  out  16  clocks-per-bit / 8, fed to the UART.
- `locked`  out  1  high once any lock has succeeded. Sticky until reset.
- `lock`  out  1  one-cycle pulse when a new `prescale` is loaded.
- `error`  out  1  one-cycle pulse when a measurement is aborted.
- `busy`  out  1  high from an accepted `arm` until `lock`/`error`.

## Operation
- `rxd` passes through a 2-flop synchronizer. All edges are detected on the synchronized signal. The fixed 2-cycle delay cancels out of every measured interval.
- 0x55 framed 8N1, LSB first, gives 10 equal segments: start 0, then 1,0,1,0,1,0,1,0, then stop 1.
- There are 5 falling edges, at bit times 0, 2, 4, 6 and 8, so first falling to last falling edge = 8 bit times = 64 × prescale clocks.
- State machine:
  - IDLE: on `arm`, go to WAIT_HIGH and set `busy`=1.
  - WAIT_HIGH: wait until the line is high, so a character already in flight is never sampled mid-frame. Then go to WAIT_START.
  - WAIT_START: on a falling edge, clear the segment counter `seg` (19 bit) and the total counter `tot` (22 bit). Go to MEASURE with the edge index at 1.
  - MEASURE:
    - `seg` and `tot` increment every cycle.
    - On each edge, `seg` is compared and cleared, and the edge index increments.
    - Segment 1 (start bit) length is latched as L.
    - Segments 2..9 must satisfy L−(L>>TOL_SHIFT) ≤ seg ≤ L+(L>>TOL_SHIFT); otherwise go to ERROR.
    - At the 9th edge (the final falling edge, start of d7), latch `tot`, go to CHECK_STOP.
  - CHECK_STOP: d7 (low) is still checked as a segment. The line must then stay high for at least L−(L>>TOL_SHIFT) clocks after the rising edge into the stop bit. A falling edge before that means ERROR. Otherwise go to DONE.
  - DONE: compute p = (tot + 32) >> 6, truncated to 16 bits.
    - If p == 0: ERROR.
    - Otherwise load `prescale`=p, pulse `lock`, set `locked`, clear `busy`, return to IDLE.
  - ERROR: pulse `error`, clear `busy`, return to IDLE. `prescale` and `locked` are unchanged.
- Timeout: in MEASURE or CHECK_STOP, `seg` reaching MAX_SEG means ERROR. `seg` and `tot` must never wrap.
- Tolerance arithmetic uses 20-bit intermediates to avoid overflow at the maximum L.

## Timing
- Reset values: `prescale`=DEFAULT_PRESCALE; `locked`=0, `lock`=0, `error`=0, `busy`=0; state IDLE.
- `busy` rises the cycle after `arm`.
- Lock latency: `lock` and the new `prescale` appear 1 cycle after the stop-bit check is satisfied (DONE is one cycle). The new `prescale` is stable from the same cycle `lock` is high.
- Edge-to-detection latency: 3 cycles from the `rxd` pin (2 synchronizer cycles + 1 registered edge detect).
- `arm` asserted in the same cycle as `lock`/`error` is ignored (block still busy).
- Reset mid-measure: all state returns to reset values immediately. No `lock`/`error` pulse is emitted.
- `lock` and `error` are never high in the same cycle.

## Structure
- Shared package `uart_pkg`:
  - autobaud state enum: IDLE, WAIT_HIGH, WAIT_START, MEASURE, CHECK_STOP, DONE, ERROR.
  - constants SYNC_SEGMENTS=9 and TOT_SHIFT=6.
- One sub-module: `uart_sync_2ff` (2-flop synchronizer, async active-low reset, reset value 1).
- The edge detector and FSM stay in `uart_autobaud`.

## Test plan
- Clean 0x55 at 432 clk/bit after `arm` → `lock` pulse, `prescale`=54, `locked`=1, `busy` low afterwards.
- 0x55 at 100 clk/bit, with one data segment stretched to 120 clocks (+20%) → `lock`, `prescale`=13. The same segment at 130 clocks → `error`, `prescale` unchanged.
- 0x41 sent instead of 0x55 → `error`. Then a clean 0x55 at 800 clk/bit → `prescale`=100.
- `arm` with the line held low for 2^19+10 cycles → `error` exactly once, `busy`=0.
- Bit period of 3 clocks → p=(24+32)>>6=0 → `error`, `prescale` stays at DEFAULT_PRESCALE.
- `rst_n` pulsed low during MEASURE → all outputs at reset values, no pulses. A subsequent `arm` plus 0x55 at 432 clk/bit → `prescale`=54.
